alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_adder.sv | 31 +++
 rtl/alu_core.sv | 120 ++++++++++++
 tb/tb_alu_core.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the alu_core slice.
//
// Contents:
//   ALU_WIDTH  default operand/result width (16 bits)
//   alu_op_e   2-bit operation select encoding
//                OP_ADD = 00, OP_SUB = 01, OP_AND = 10, OP_OR = 11
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_adder.sv
// ---------------------------------------------------------------------------
// alu_adder -- WIDTH-bit ripple/inferred adder with carry-in and carry-out.
// One instance is shared by ADD and SUB inside alu_core.
//
// Parameters:
//   WIDTH  operand width in bits
// Ports:
//   a     input  [WIDTH-1:0]  first addend
//   b     input  [WIDTH-1:0]  second addend
//   cin   input               carry in
//   sum   output [WIDTH-1:0]  (a + b + cin) mod 2^WIDTH
//   cout  output              carry out of the MSB
// ---------------------------------------------------------------------------
module alu_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] full;

  // Zero-extend everything to WIDTH+1 bits so the top bit is the carry out.
  assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];

endmodule : alu_adder

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core -- 4-operation ALU with a single registered output stage.
//
// The result is formed combinationally from op/i0/i1 and captured on every
// rising clk edge (latency exactly one cycle, no enable, no handshake).
//
// Parameters:
//   WIDTH  operand/result width (only 16 is required)
// Ports:
//   clk    input               rising-edge clock
//   reset  input               asynchronous, active-low reset
//   op     input  [1:0]        00 ADD, 01 SUB, 10 AND, 11 OR
//   i0     input  [WIDTH-1:0]  operand A
//   i1     input  [WIDTH-1:0]  operand B
//   o      output [WIDTH-1:0]  registered result
//   cout   output              registered carry / no-borrow flag
// Optional (macro ALU_FLAGS_EN defined):
//   zero   output              registered (o == 0)
//   neg    output              registered o[MSB]
//   ovf    output              registered signed overflow of ADD/SUB
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] o,
  output logic             cout
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  alu_op_e          op_sel;
  logic             is_sub;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] res_d;
  logic             cout_d;

  assign op_sel = alu_op_e'(op);

  // SUB reuses the adder as A + ~B + 1, so its carry out reads as "no borrow".
  assign is_sub = (op_sel == OP_SUB);
  assign add_b  = is_sub ? ~i1 : i1;

  alu_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (i0),
    .b    (add_b),
    .cin  (is_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    case (op_sel)
      OP_ADD, OP_SUB: begin
        res_d  = add_sum;
        cout_d = add_cout;
      end
      OP_AND: res_d = i0 & i1;
      OP_OR:  res_d = i0 | i1;
      default: begin
        res_d  = '0;
        cout_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o    <= '0;
      cout <= 1'b0;
    end else begin
      o    <= res_d;
      cout <= cout_d;
    end
  end

`ifdef ALU_FLAGS_EN
  logic ovf_d;

  // Overflow is judged on the operands the adder actually sees: the result
  // sign differs from A while A and the (possibly inverted) B agree in sign.
  // For SUB that is exactly "A and B differ in sign, result sign != A sign".
  always_comb begin
    ovf_d = 1'b0;
    if (op_sel == OP_ADD || op_sel == OP_SUB) begin
      ovf_d = (i0[WIDTH-1] == add_b[WIDTH-1]) &&
              (add_sum[WIDTH-1] != i0[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero <= 1'b0;
      neg  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      zero <= (res_d == '0);
      neg  <= res_d[WIDTH-1];
      ovf  <= ovf_d;
    end
  end
`endif

endmodule : alu_core

// File: tb/tb_alu_core.sv
// ---------------------------------------------------------------------------
// tb_alu_core -- self-checking bench for alu_core.
// Expected results are pushed to a scoreboard queue when operands are driven
// (on the falling edge) and popped/compared 1 time unit after the next rising
// edge. Define ALU_FLAGS_EN to also check zero/neg/ovf.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_core;

  typedef struct {
    logic [15:0] o;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  op;
  logic [15:0] i0;
  logic [15:0] i1;
  logic [15:0] o;
  logic        cout;
`ifdef ALU_FLAGS_EN
  logic        zero;
  logic        neg;
  logic        ovf;
`endif

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  alu_core #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .i0    (i0),
    .i1    (i1),
    .o     (o),
    .cout  (cout)
`ifdef ALU_FLAGS_EN
    ,
    .zero  (zero),
    .neg   (neg),
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one operation and push the reference result built from plain
  // unsigned/signed integer arithmetic.
  task automatic drive_op(input logic [1:0] op_v, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   sa;
    int   sbv;
    int   sr;
    op = op_v;
    i0 = a;
    i1 = b;
    sa  = $signed(a);
    sbv = $signed(b);
    e.ovf = 1'b0;
    case (op_v)
      2'b00: begin
        e.o    = 16'(int'(a) + int'(b));
        e.cout = (int'(a) + int'(b)) > 65535;
        sr     = sa + sbv;
        e.ovf  = (sr > 32767) || (sr < -32768);
      end
      2'b01: begin
        e.o    = 16'(int'(a) - int'(b));
        e.cout = (a >= b);
        sr     = sa - sbv;
        e.ovf  = (sr > 32767) || (sr < -32768);
      end
      2'b10: begin
        e.o    = a & b;
        e.cout = 1'b0;
      end
      default: begin
        e.o    = a | b;
        e.cout = 1'b0;
      end
    endcase
    e.zero = (e.o == 16'h0000);
    e.neg  = e.o[15];
    sb.push_back(e);
  endtask

  // Reset held low with operands toggling, then the first capture after release.
  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    op = 2'b00; i0 = '0; i1 = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      op = 2'($urandom_range(0, 3));
      i0 = 16'($urandom);
      i1 = 16'($urandom);
      @(posedge clk); #1;
      checks++;
      if (o !== 16'h0000 || cout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold[%0d]: got o=%h cout=%b want o=0000 cout=0", k, o, cout);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if ({zero, neg, ovf} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL reset_flags[%0d]: got zno=%b want 000", k, {zero, neg, ovf});
      end
`endif
    end
    @(negedge clk);
    reset = 1'b1;
    drive_op(2'b00, 16'h1234, 16'h0001);
    #1;
    checks++;
    if (o !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_release_nocapture: got o=%h want 0000", o);
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (o !== e.o || cout !== e.cout) begin
      errors++;
      $display("[TB] FAIL reset_first_result: got o=%h cout=%b want o=%h cout=%b", o, cout, e.o, e.cout);
    end
  endtask

  // Fixed vectors for one op code; each result checked one edge later.
  task automatic test_op(input string name, input logic [1:0] op_v);
    logic [15:0] va[4];
    logic [15:0] vb[4];
    exp_t e;
    va = '{16'haa55, 16'hffff, 16'h0001, 16'h0000};
    vb = '{16'h55aa, 16'h0001, 16'h7fff, 16'h0000};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_op(op_v, va[k], vb[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (o !== e.o || cout !== e.cout) begin
        errors++;
        $display("[TB] FAIL %s[%0d] %h,%h: got o=%h cout=%b want o=%h cout=%b",
                 name, k, va[k], vb[k], o, cout, e.o, e.cout);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (zero !== e.zero || neg !== e.neg || ovf !== e.ovf) begin
        errors++;
        $display("[TB] FAIL %s_flags[%0d]: got zno=%b%b%b want %b%b%b",
                 name, k, zero, neg, ovf, e.zero, e.neg, e.ovf);
      end
`endif
    end
  endtask

  // Spot-check a few spec values against literal constants as well.
  task automatic test_known_values();
    exp_t e;
    @(negedge clk); drive_op(2'b01, 16'h0001, 16'h7fff);
    @(posedge clk); #1; e = sb.pop_front();
    checks++;
    if (o !== 16'h8002 || cout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sub_0001_7fff: got o=%h cout=%b want o=8002 cout=0", o, cout);
    end
    @(negedge clk); drive_op(2'b00, 16'hffff, 16'h0001);
    @(posedge clk); #1; e = sb.pop_front();
    checks++;
    if (o !== 16'h0000 || cout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_ffff_0001: got o=%h cout=%b want o=0000 cout=1", o, cout);
    end
`ifdef ALU_FLAGS_EN
    @(negedge clk); drive_op(2'b00, 16'h0001, 16'h7fff);
    @(posedge clk); #1; e = sb.pop_front();
    checks++;
    if (o !== 16'h8000 || ovf !== 1'b1 || neg !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_ovf: got o=%h ovf=%b neg=%b want o=8000 ovf=1 neg=1", o, ovf, neg);
    end
`endif
  endtask

  // Operands changing between edges must not disturb the held result.
  task automatic test_hold();
    exp_t e;
    @(negedge clk); drive_op(2'b11, 16'h0f00, 16'h00f0);
    @(posedge clk); #1; e = sb.pop_front();
    checks++;
    if (o !== e.o) begin
      errors++;
      $display("[TB] FAIL hold_capture: got o=%h want o=%h", o, e.o);
    end
    #2;
    op = 2'b00; i0 = 16'hffff; i1 = 16'hffff;
    #1;
    checks++;
    if (o !== 16'h0ff0 || cout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_between_edges: got o=%h cout=%b want o=0ff0 cout=0", o, cout);
    end
  endtask

  // One new random operation every cycle.
  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      drive_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (o !== e.o || cout !== e.cout) begin
        errors++;
        $display("[TB] FAIL b2b[%0d] op=%b %h,%h: got o=%h cout=%b want o=%h cout=%b",
                 k, op, i0, i1, o, cout, e.o, e.cout);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (zero !== e.zero || neg !== e.neg || ovf !== e.ovf) begin
        errors++;
        $display("[TB] FAIL b2b_flags[%0d]: got zno=%b%b%b want %b%b%b",
                 k, zero, neg, ovf, e.zero, e.neg, e.ovf);
      end
`endif
    end
  endtask

  // Reset asserted between edges clears outputs at once and drops the pending ADD.
  task automatic test_async_reset();
    exp_t e;
    @(negedge clk); drive_op(2'b11, 16'hffff, 16'h0001);
    @(posedge clk); #1; e = sb.pop_front();
    checks++;
    if (o !== 16'hffff) begin
      errors++;
      $display("[TB] FAIL async_pre: got o=%h want ffff", o);
    end
    @(negedge clk);
    op = 2'b00; i0 = 16'hffff; i1 = 16'h0001;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (o !== 16'h0000 || cout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_immediate: got o=%h cout=%b want o=0000 cout=0", o, cout);
    end
    @(posedge clk); #1;
    checks++;
    if (o !== 16'h0000 || cout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_discard: got o=%h cout=%b want o=0000 cout=0", o, cout);
    end
    @(negedge clk);
    reset = 1'b1;
    drive_op(2'b01, 16'h0000, 16'h0001);
    @(posedge clk); #1; e = sb.pop_front();
    checks++;
    if (o !== e.o || cout !== e.cout) begin
      errors++;
      $display("[TB] FAIL async_recover: got o=%h cout=%b want o=%h cout=%b", o, cout, e.o, e.cout);
    end
  endtask

  initial begin
    test_reset();
    test_op("add", 2'b00);
    test_op("sub", 2'b01);
    test_op("and", 2'b10);
    test_op("or",  2'b11);
    test_known_values();
    test_hold();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_core
